// File: rtl/apb_mem_slave_wide.sv
// apb_mem_slave_wide: parametrised APB memory slave with byte strobes, programmable wait
// states, out-of-range error response and abort on psel drop.
//
// Ports:
//   pclk_i     clock, all logic on the rising edge
//   preset_i   synchronous active-high reset (memory array is not cleared)
//   psel_i     slave select
//   penable_i  access phase
//   pwrite_i   1 = write, 0 = read
//   paddr_i    byte address; sub-word bits are ignored
//   pwdata_i   write data
//   pstrb_i    byte write enables
//   pwait_i    wait states to insert, sampled in the setup cycle
//   pready_o   transfer complete (registered)
//   prdata_o   read data (registered, holds between reads)
//   pslverr_o  error flag, valid while pready_o = 1
module apb_mem_slave_wide #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 32,
  parameter int unsigned WAIT_WIDTH = 4
) (
  input  logic                      pclk_i,
  input  logic                      preset_i,
  input  logic                      psel_i,
  input  logic                      penable_i,
  input  logic                      pwrite_i,
  input  logic [ADDR_WIDTH-1:0]     paddr_i,
  input  logic [DATA_WIDTH-1:0]     pwdata_i,
  input  logic [DATA_WIDTH/8-1:0]   pstrb_i,
  input  logic [WAIT_WIDTH-1:0]     pwait_i,
  output logic                      pready_o,
  output logic [DATA_WIDTH-1:0]     prdata_o,
  output logic                      pslverr_o
);

  localparam int unsigned NumBytes = DATA_WIDTH / 8;
  localparam int unsigned ByteIdxW = $clog2(NumBytes);
  localparam int unsigned IdxW     = ADDR_WIDTH - ByteIdxW;
  localparam int unsigned MemAw    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // One extra bit so DEPTH == 2**IdxW is representable.
  localparam logic [IdxW:0] DepthW = (IdxW + 1)'(DEPTH);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e                  state_q, state_d;
  logic [WAIT_WIDTH-1:0]   cnt_q, cnt_d;
  logic [WAIT_WIDTH-1:0]   wait_lat_q, wait_lat_d;
  logic [MemAw-1:0]        idx_q, idx_d;
  logic                    write_q, write_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [NumBytes-1:0]     strb_q, strb_d;
  logic                    err_q, err_d;
  logic                    pready_q, pready_d;
  logic                    pslverr_q, pslverr_d;
  logic [DATA_WIDTH-1:0]   prdata_q, prdata_d;

  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

  logic [IdxW-1:0]         setup_idx;
  logic                    setup_err;
  logic [MemAw-1:0]        rd_idx;
  logic [DATA_WIDTH-1:0]   rd_data;

  assign setup_idx = paddr_i[ADDR_WIDTH-1:ByteIdxW];
  assign setup_err = ({1'b0, setup_idx} >= DepthW);

  // Out-of-range indices only ever reach the memory with err set, so the truncated index
  // is only used for in-range accesses.
  assign rd_idx  = (state_q == StIdle) ? setup_idx[MemAw-1:0] : idx_q;
  assign rd_data = mem_q[rd_idx];

  generate
    if (ByteIdxW > 0) begin : g_unused_low
      logic unused_paddr_low;
      assign unused_paddr_low = ^paddr_i[ByteIdxW-1:0];
    end
  endgenerate

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    wait_lat_d = wait_lat_q;
    idx_d      = idx_q;
    write_d    = write_q;
    wdata_d    = wdata_q;
    strb_d     = strb_q;
    err_d      = err_q;
    pready_d   = 1'b0;
    pslverr_d  = 1'b0;
    prdata_d   = prdata_q;

    unique case (state_q)
      StIdle: begin
        // psel with penable in IDLE is not a valid setup and is ignored.
        if (psel_i && !penable_i) begin
          idx_d      = setup_idx[MemAw-1:0];
          write_d    = pwrite_i;
          wdata_d    = pwdata_i;
          strb_d     = pstrb_i;
          wait_lat_d = pwait_i;
          err_d      = setup_err;
          if (pwait_i == '0) begin
            state_d   = StResp;
            pready_d  = 1'b1;
            pslverr_d = setup_err;
            if (!pwrite_i) begin
              prdata_d = setup_err ? '0 : rd_data;
            end
          end else begin
            state_d = StWait;
            cnt_d   = WAIT_WIDTH'(1);
          end
        end
      end

      StWait: begin
        if (!psel_i) begin
          // Master abandoned the transfer: no memory access, no pready.
          state_d = StIdle;
          cnt_d   = '0;
        end else if (penable_i) begin
          if (cnt_q == wait_lat_q) begin
            state_d   = StResp;
            pready_d  = 1'b1;
            pslverr_d = err_q;
            if (!write_q) begin
              prdata_d = err_q ? '0 : rd_data;
            end
          end else begin
            cnt_d = cnt_q + WAIT_WIDTH'(1);
          end
        end
      end

      StResp: begin
        state_d = StIdle;
        cnt_d   = '0;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge pclk_i) begin
    if (preset_i) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      wait_lat_q <= '0;
      idx_q      <= '0;
      write_q    <= 1'b0;
      wdata_q    <= '0;
      strb_q     <= '0;
      err_q      <= 1'b0;
      pready_q   <= 1'b0;
      pslverr_q  <= 1'b0;
      prdata_q   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wait_lat_q <= wait_lat_d;
      idx_q      <= idx_d;
      write_q    <= write_d;
      wdata_q    <= wdata_d;
      strb_q     <= strb_d;
      err_q      <= err_d;
      pready_q   <= pready_d;
      pslverr_q  <= pslverr_d;
      prdata_q   <= prdata_d;
    end
  end

  // Writes commit at the closing edge of the completion cycle; reset drops them.
  always_ff @(posedge pclk_i) begin
    if (!preset_i && (state_q == StResp) && write_q && !err_q) begin
      for (int i = 0; i < int'(NumBytes); i++) begin
        if (strb_q[i]) begin
          mem_q[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
        end
      end
    end
  end

  assign pready_o  = pready_q;
  assign pslverr_o = pslverr_q;
  assign prdata_o  = prdata_q;

endmodule

// File: tb/tb_apb_mem_slave_wide.sv
module tb_apb_mem_slave_wide;

  logic        clk = 1'b0;
  logic        preset;
  logic        psel, penable, pwrite;
  logic [7:0]  paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [3:0]  pwait;
  logic        pready;
  logic [31:0] prdata;
  logic        pslverr;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  apb_mem_slave_wide #(
    .ADDR_WIDTH(8),
    .DATA_WIDTH(32),
    .DEPTH     (32),
    .WAIT_WIDTH(4)
  ) dut (
    .pclk_i   (clk),
    .preset_i (preset),
    .psel_i   (psel),
    .penable_i(penable),
    .pwrite_i (pwrite),
    .paddr_i  (paddr),
    .pwdata_i (pwdata),
    .pstrb_i  (pstrb),
    .pwait_i  (pwait),
    .pready_o (pready),
    .prdata_o (prdata),
    .pslverr_o(pslverr)
  );

  // Reference model: word array plus the last value a read returned.
  logic [31:0] mdl [32];
  logic [31:0] last_rd;

  typedef struct {
    bit          wr;
    logic [7:0]  a;
    logic [31:0] d;
    logic [3:0]  s;
    logic [3:0]  w;
    bit          er;
    logic [31:0] rd;
  } vec_t;

  vec_t vt[14];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic mdl_xfer(input bit wr, input logic [7:0] a, input logic [31:0] d,
                          input logic [3:0] s, output logic [31:0] rd, output logic er);
    int idx;
    idx = int'(a) / 4;
    er  = (idx >= 32);
    if (wr) begin
      if (!er) begin
        for (int i = 0; i < 4; i++) begin
          if (s[i]) mdl[idx % 32][8*i +: 8] = d[8*i +: 8];
        end
      end
    end else begin
      last_rd = er ? 32'h0 : mdl[idx % 32];
    end
    rd = last_rd;
  endtask

  // Starts and ends 1 time unit after a rising edge, leaving the bus idle-driven so the
  // next call can begin its setup in the very next cycle.
  task automatic xfer(input bit wr, input logic [7:0] a, input logic [31:0] d,
                      input logic [3:0] s, input logic [3:0] w,
                      output logic [31:0] rd, output logic er, output int acc);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d; pstrb = s; pwait = w;
    @(posedge clk); #1;
    penable = 1'b1;
    acc = 1;
    while (pready !== 1'b1 && acc < 40) begin
      @(posedge clk); #1;
      acc++;
    end
    rd = prdata;
    er = pslverr;
    if (pready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL timeout: pready got %b expected 1 within 40 cycles", pready);
    end
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic run(input string nm, input bit wr, input logic [7:0] a, input logic [31:0] d,
                     input logic [3:0] s, input logic [3:0] w);
    logic [31:0] erd, ard;
    logic        eer, aer;
    int          acc;
    mdl_xfer(wr, a, d, s, erd, eer);
    xfer(wr, a, d, s, w, ard, aer, acc);
    chk({nm, " rdata"}, ard, erd);
    chk({nm, " err"}, 32'(aer), 32'(eer));
    chk({nm, " cycles"}, 32'(acc), 32'(w) + 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ard, erd;
    logic        aer, eer;
    int          acc, c0;

    vt[0]  = '{1'b1, 8'h10, 32'hDEADBEEF, 4'hF, 4'd0,  1'b0, 32'h0};
    vt[1]  = '{1'b0, 8'h10, 32'h0,        4'h0, 4'd0,  1'b0, 32'hDEADBEEF};
    vt[2]  = '{1'b1, 8'h04, 32'h11223344, 4'hF, 4'd3,  1'b0, 32'hDEADBEEF};
    vt[3]  = '{1'b0, 8'h04, 32'h0,        4'h0, 4'd15, 1'b0, 32'h11223344};
    vt[4]  = '{1'b1, 8'h08, 32'hAABBCCDD, 4'hF, 4'd0,  1'b0, 32'h11223344};
    vt[5]  = '{1'b1, 8'h08, 32'h00000099, 4'h1, 4'd0,  1'b0, 32'h11223344};
    vt[6]  = '{1'b0, 8'h08, 32'h0,        4'h0, 4'd0,  1'b0, 32'hAABBCC99};
    vt[7]  = '{1'b1, 8'h08, 32'h12345678, 4'h0, 4'd2,  1'b0, 32'hAABBCC99};
    vt[8]  = '{1'b0, 8'h0B, 32'h0,        4'h0, 4'd1,  1'b0, 32'hAABBCC99};
    vt[9]  = '{1'b1, 8'h00, 32'h0BADF00D, 4'hF, 4'd0,  1'b0, 32'hAABBCC99};
    vt[10] = '{1'b1, 8'h80, 32'h00000055, 4'hF, 4'd0,  1'b1, 32'hAABBCC99};
    vt[11] = '{1'b0, 8'h84, 32'h0,        4'h0, 4'd0,  1'b1, 32'h0};
    vt[12] = '{1'b0, 8'h00, 32'h0,        4'h0, 4'd0,  1'b0, 32'h0BADF00D};
    vt[13] = '{1'b0, 8'h13, 32'h0,        4'h0, 4'd2,  1'b0, 32'hDEADBEEF};

    last_rd = 32'h0;
    for (int i = 0; i < 32; i++) mdl[i] = 32'h0;

    preset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; pstrb = '0; pwait = '0;
    repeat (3) @(posedge clk);
    #1;
    preset = 1'b0;
    chk("reset pready", 32'(pready), 32'h0);
    chk("reset pslverr", 32'(pslverr), 32'h0);
    chk("reset prdata", prdata, 32'h0);

    // Directed table.
    for (int i = 0; i < 14; i++) begin
      mdl_xfer(vt[i].wr, vt[i].a, vt[i].d, vt[i].s, erd, eer);
      xfer(vt[i].wr, vt[i].a, vt[i].d, vt[i].s, vt[i].w, ard, aer, acc);
      chk($sformatf("vec%0d rdata", i), ard, vt[i].rd);
      chk($sformatf("vec%0d err", i), 32'(aer), 32'(vt[i].er));
      chk($sformatf("vec%0d cycles", i), 32'(acc), 32'(vt[i].w) + 32'd1);
    end

    // Give every word a known value so random reads are well defined.
    for (int i = 0; i < 32; i++) begin
      run($sformatf("init%0d", i), 1'b1, 8'(i * 4), 32'h1000_0000 + 32'(i) * 32'h0101_0101,
          4'hF, 4'd0);
    end

    // Abort: drop psel after two access cycles of a pwait=5 write.
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h20; pwdata = 32'hCAFEF00D;
    pstrb = 4'hF; pwait = 4'd5;
    @(posedge clk); #1;
    penable = 1'b1;
    chk("abort acc1 pready", 32'(pready), 32'h0);
    @(posedge clk); #1;
    chk("abort acc2 pready", 32'(pready), 32'h0);
    psel = 1'b0; penable = 1'b0;
    @(posedge clk); #1;
    chk("abort idle1 pready", 32'(pready), 32'h0);
    @(posedge clk); #1;
    chk("abort idle2 pready", 32'(pready), 32'h0);
    run("abort readback", 1'b0, 8'h20, 32'h0, 4'h0, 4'd0);

    // Reset in the middle of a waiting write.
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h24; pwdata = 32'h13572468;
    pstrb = 4'hF; pwait = 4'd4;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    preset = 1'b1; psel = 1'b0; penable = 1'b0;
    @(posedge clk); #1;
    preset = 1'b0;
    last_rd = 32'h0;
    chk("midreset pready", 32'(pready), 32'h0);
    chk("midreset pslverr", 32'(pslverr), 32'h0);
    chk("midreset prdata", prdata, 32'h0);
    c0 = cyc;
    run("b2b read1", 1'b0, 8'h24, 32'h0, 4'h0, 4'd0);
    run("b2b read2", 1'b0, 8'h10, 32'h0, 4'h0, 4'd0);
    chk("b2b total cycles", 32'(cyc - c0), 32'd4);

    // Random traffic, including out-of-range addresses and maximum wait.
    for (int n = 0; n < 400; n++) begin
      bit          wr;
      logic [7:0]  a;
      logic [3:0]  w;
      wr = 1'($urandom_range(0, 1));
      a  = 8'($urandom_range(0, 159));
      w  = ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
      run($sformatf("rnd%0d", n), wr, a, $urandom, 4'($urandom_range(0, 15)), w);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/apb_mem_slave_wide.md
Name: apb_mem_slave_wide

Overview:
Parametrised APB memory slave, successor to the fixed 8-bit/256-entry memory slave. Adds configurable data width, depth and wait-state width, byte strobes, out-of-range error response (pslverr) and clean abort on protocol violation. Sits behind the APB master or decoder as a simulation and synthesis target with programmable access latency.

Parameters:
ADDR_WIDTH, 8, byte-address width of paddr.
DATA_WIDTH, 32, data bus width; one of 8, 16, 32 or 64.
DEPTH, 32, number of DATA_WIDTH-bit words; must be at most 2**(ADDR_WIDTH-log2(DATA_WIDTH/8)).
WAIT_WIDTH, 4, width of the pwait input and the internal wait counter.

Ports:
pclk  in  1  clock; all logic on rising edge.
preset  in  1  synchronous reset, active-high.
psel  in  1  slave select.
penable  in  1  APB access phase.
pwrite  in  1  1 = write, 0 = read.
paddr  in  ADDR_WIDTH  byte address; word index = paddr[ADDR_WIDTH-1:log2(DATA_WIDTH/8)].
pwdata  in  DATA_WIDTH  write data.
pstrb  in  DATA_WIDTH/8  byte write enables.
pwait  in  WAIT_WIDTH  wait states to insert; sampled in setup cycle.
pready  out  1  transfer complete (registered).
prdata  out  DATA_WIDTH  read data (registered).
pslverr  out  1  error flag; valid only while pready=1.

Behaviour:
- Reset (preset=1 at edge): state=IDLE, pready=0, pslverr=0, prdata=0, wait count=0. Memory array is not cleared. Reset wins over every other event, including mid-transfer; an in-flight write is dropped.
- FSM states: IDLE, WAIT, RESP. All outputs come from registers.
- IDLE: at an edge with psel=1 and penable=0 (setup cycle), latch paddr, pwrite, pwdata, pstrb and pwait as wait_lat. Compute err = (word index >= DEPTH).
  - If pwait=0: go to RESP with pready<=1 and pslverr<=err.
  - Otherwise: go to WAIT with count<=1.
  - psel=1 with penable=1 while in IDLE is ignored and the slave stays in IDLE.
- WAIT: at each edge with psel=1 and penable=1:
  - If count==wait_lat: go to RESP with pready<=1 and pslverr<=err.
  - Otherwise: count<=count+1.
  - If psel=0 at any WAIT edge: abort to IDLE with no memory access and pready staying 0.
- RESP: lasts exactly one cycle, the completion cycle with pready=1. At its closing edge:
  - Commit a write if !err: each byte lane i with pstrb[i]=1 is written; other lanes keep their old value.
  - pready<=0, pslverr<=0, go to IDLE unconditionally.
  - A back-to-back setup in the following cycle is therefore sampled in IDLE.
- Read data: prdata is loaded at the edge entering RESP with mem[index] for a read without error, or 0 for a read with error. It holds its value through writes and idle cycles.
- Latency: access-phase cycles per transfer = pwait+1. Total transfer = pwait+2 cycles including setup. Back-to-back transfers have no dead cycle.
- The wait count never exceeds wait_lat, so no wrap. pwait = 2**WAIT_WIDTH-1 is legal and gives maximum latency.
- Read-after-write to the same address in the next transfer returns the new data.
- Error writes never modify memory. pstrb=0 on a write completes normally with no change to memory.
- paddr low (sub-word) bits are ignored.

Test Plan:
(Defaults: ADDR_WIDTH=8, DATA_WIDTH=32, DEPTH=32, WAIT_WIDTH=4.)
1. Reset, then write 0xDEADBEEF to paddr=0x10 with pstrb=0xF, pwait=0 → pready=1 in the first access cycle, pslverr=0. Read 0x10 with pwait=0 → prdata=0xDEADBEEF.
2. Write 0x11223344 to paddr=0x04 with pwait=3 → pready stays 0 for 3 access cycles and is 1 in the 4th. Readback with pwait=15 → 16 access cycles, prdata=0x11223344.
3. Preload 0xAABBCCDD at paddr=0x08, then write 0x00000099 with pstrb=0x1 → readback 0xAABBCC99. Write with pstrb=0x0 → readback unchanged.
4. Write 0x55 to paddr=0x80 (index 32) → pready=1, pslverr=1, memory unchanged. Read 0x84 → pslverr=1, prdata=0. Next good read → pslverr=0.
5. Start a write with pwait=5, drop psel after 2 access cycles → FSM returns to IDLE, pready never asserts, memory unchanged. Next transfer completes normally.
6. Assert preset during WAIT of a write → pready=0, prdata=0 next cycle, write not committed. Two back-to-back reads after reset release → each completes with no idle cycle between them.
